// File: rtl/stack.sv
// Synchronous LIFO of DATA_W-bit words with registered pop output and count/full/empty status.
// Optional overflow/underflow sticky flags are enabled by defining STACK_ERR_FLAGS_EN.
module stack #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [PTR_W-1:0]  count
`ifdef STACK_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int AW = PTR_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  count_reg;
  logic [PTR_W-1:0]  count_next;
  logic [DATA_W-1:0] data_out_reg;
  logic [AW-1:0]     top_addr;
  logic [AW-1:0]     wr_addr;
  logic              push_pop;
  logic              push_only;
  logic              pop_only;
  logic              mem_we;
  logic              mem_re;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == PTR_W'(DEPTH));

  // When full the low address bits wrap to 0, so top-1 lands on DEPTH-1 as required.
  assign top_addr  = count_reg[AW-1:0] - AW'(1);
  assign push_pop  = write_en & read_en;
  assign push_only = write_en & ~read_en & ~full;
  assign pop_only  = read_en & ~write_en & ~empty;

  // A simultaneous push+pop on a non-empty stack replaces the top slot in place.
  assign mem_we  = push_only | (push_pop & ~empty);
  assign mem_re  = pop_only  | (push_pop & ~empty);
  assign wr_addr = push_only ? count_reg[AW-1:0] : top_addr;

  always_comb begin
    count_next = count_reg;
    if (push_only) begin
      count_next = count_reg + PTR_W'(1);
    end else if (pop_only) begin
      count_next = count_reg - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Nonblocking semantics give the pre-push top when read and write share an address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
    end else if (push_pop & empty) begin
      data_out_reg <= data_in;
    end else if (mem_re) begin
      data_out_reg <= mem[top_addr];
    end
  end

  assign data_out = data_out_reg;
  assign count    = count_reg;

`ifdef STACK_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (write_en & ~read_en & full) begin
        overflow_reg <= 1'b1;
      end
      if (read_en & ~write_en & empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_stack.sv
// Randomized scoreboard bench for stack: a queue-based LIFO model predicts each cycle's outputs.
// Flag checks are compiled in when STACK_ERR_FLAGS_EN is defined.
module tb_stack;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              read_en = 1'b0;
  logic              write_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic [PTR_W-1:0]  count;
`ifdef STACK_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read_en  (read_en),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef STACK_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    int          cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_q[$];
  logic [31:0] m_dout;
  logic        m_ovf;
  logic        m_udf;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Reference behaviour: a queue whose back is the top of the stack.
  task automatic model_step(input logic we, input logic re, input logic [31:0] din);
    if (we && re) begin
      if (model_q.size() == 0) begin
        m_dout = din;
      end else begin
        m_dout = model_q[model_q.size()-1];
        model_q[model_q.size()-1] = din;
      end
    end else if (we) begin
      if (model_q.size() < DEPTH) model_q.push_back(din);
      else m_ovf = 1'b1;
    end else if (re) begin
      if (model_q.size() > 0) m_dout = model_q.pop_back();
      else m_udf = 1'b1;
    end
  endtask

  task automatic do_cycle(input logic we, input logic re, input logic [31:0] din);
    exp_t e;
    @(negedge clk);
    write_en = we;
    read_en  = re;
    data_in  = din;
    model_step(we, re, din);
    e.we   = we;
    e.re   = re;
    e.din  = din;
    e.dout = m_dout;
    e.cnt  = model_q.size();
    e.emp  = (model_q.size() == 0);
    e.ful  = (model_q.size() == DEPTH);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_dout"},  data_out, 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full), 32'd0);
`ifdef STACK_ERR_FLAGS_EN
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_udf"}, 32'(underflow), 32'd0);
`endif
  endtask

  // Idle cycle, then assert reset asynchronously between clock edges.
  task automatic mid_cycle_reset();
    do_cycle(1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    check("sb_drained_before_reset", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one scoreboard entry is retired just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn we=%0b re=%0b din=%h dout=%h count=%0d empty=%0b full=%0b",
                 e.we, e.re, e.din, data_out, count, empty, full);
        check("data_out", data_out, e.dout);
        check("count", 32'(count), 32'(e.cnt));
        check("empty", 32'(empty), 32'(e.emp));
        check("full", 32'(full), 32'(e.ful));
`ifdef STACK_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("underflow", 32'(underflow), 32'(e.udf));
`endif
      end
    end
  end

  initial begin
    int p;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_reset_state("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic LIFO order
    do_cycle(1, 0, 32'h11);
    do_cycle(1, 0, 32'h22);
    do_cycle(1, 0, 32'h33);
    repeat (3) do_cycle(0, 1, 32'h0);

    // Fill to full, ignored push, pop top, drain, pop on empty
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 32'(i));
    do_cycle(1, 0, 32'hFF);
    do_cycle(0, 1, 32'h0);
    do_cycle(1, 1, 32'hABCD);
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 1, 32'h0);
    do_cycle(0, 1, 32'h0);

    // Pop on empty straight after reset
    mid_cycle_reset();
    do_cycle(0, 1, 32'h0);
    do_cycle(0, 0, 32'h0);

    // Push+pop with data present, then on empty stack
    do_cycle(1, 0, 32'hA);
    do_cycle(1, 0, 32'hB);
    do_cycle(1, 1, 32'hC);
    do_cycle(0, 1, 32'h0);
    do_cycle(0, 1, 32'h0);
    do_cycle(1, 1, 32'h5A);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 32'h100 + 32'(i));
    mid_cycle_reset();
    do_cycle(0, 1, 32'h0);

    // Randomized phases alternating push-heavy and pop-heavy traffic
    for (int ph = 0; ph < 8; ph++) begin
      p = (ph % 2 == 0) ? 80 : 25;
      for (int c = 0; c < 50; c++) begin
        do_cycle(($urandom_range(0, 99) < p), ($urandom_range(0, 99) < (100 - p)), $urandom);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained_at_end", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
